// File: rtl/bus_rr_arbiter_if.sv
// Handshake bundle between N bus masters, the round-robin arbiter
// and the single shared slave port.
interface bus_rr_arbiter_if #(
    parameter int MASTER_IFACE_CNT = 3
);
    logic [32*MASTER_IFACE_CNT-1:0] addr;
    logic [32*MASTER_IFACE_CNT-1:0] wdata;
    logic [32*MASTER_IFACE_CNT-1:0] rdata;
    logic [4*MASTER_IFACE_CNT-1:0]  wen;
    logic [MASTER_IFACE_CNT-1:0]    valid;
    logic [MASTER_IFACE_CNT-1:0]    ready;
    logic [31:0]                    s_addr;
    logic [31:0]                    s_wdata;
    logic [3:0]                     s_wen;
    logic                           s_valid;
    logic [31:0]                    s_rdata;
    logic                           s_ready;
    logic [31:0]                    currmaster;
    logic                           timeout_irq;

    // arbiter view: it masters the downstream slave
    modport master (
        input  addr, wdata, wen, valid,
        input  s_rdata, s_ready,
        output rdata, ready,
        output s_addr, s_wdata, s_wen, s_valid,
        output currmaster, timeout_irq
    );

    modport slave (
        output addr, wdata, wen, valid,
        output s_rdata, s_ready,
        input  rdata, ready,
        input  s_addr, s_wdata, s_wen, s_valid,
        input  currmaster, timeout_irq
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: N masters share one slave port, with a
// per-transaction wait timeout that forces completion.
module bus_rr_arbiter #(
    parameter int MASTER_IFACE_CNT = 3,
    parameter int TIMEOUT_CYCLES   = 1023
) (
    input  logic             clk,
    input  logic             resetn,
    bus_rr_arbiter_if.master bus
);
    localparam int N  = MASTER_IFACE_CNT;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
    localparam logic [15:0]   TMO      = 16'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   grant, grant_d;
    logic [IW-1:0]   last, last_d;
    logic [IW-1:0]   pick;
    logic [15:0]     wait_cnt, wait_cnt_d;
    logic [1:0]      rst_sync;
    logic            rst_n;
    logic            found;
    int              idx;
    logic            tmo;
    logic [N-1:0]    rdy;
    logic [32*N-1:0] rdat;
    logic            sval;
    logic            irq;

    // async assert, two-flop synchronised release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && bus.valid[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign tmo = (state == BUSY) && bus.valid[grant]
              && !bus.s_ready && (wait_cnt == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= LAST_RST;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            last     <= last_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        last_d     = last;
        wait_cnt_d = wait_cnt;
        case (state)
            IDLE: begin
                if (|bus.valid) begin
                    grant_d    = pick;
                    wait_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (bus.s_ready || !bus.valid[grant] || tmo) begin
                    state_d = IDLE;
                    last_d  = grant;
                end else begin
                    wait_cnt_d = wait_cnt + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        rdat = {N{bus.s_rdata}};
        rdy  = '0;
        sval = 1'b0;
        irq  = 1'b0;
        if (state == BUSY) begin
            sval       = bus.valid[grant];
            rdy[grant] = bus.s_ready;
            if (tmo) begin
                rdy[grant]                 = 1'b1;
                rdat[{grant, 5'b0} +: 32]  = 32'hDEADBEEF;
                sval                       = 1'b0;
                irq                        = 1'b1;
            end
        end
    end

    assign bus.s_addr      = bus.addr[{grant, 5'b0} +: 32];
    assign bus.s_wdata     = bus.wdata[{grant, 5'b0} +: 32];
    assign bus.s_wen       = bus.wen[{grant, 2'b0} +: 4];
    assign bus.s_valid     = sval;
    assign bus.ready       = rdy;
    assign bus.rdata       = rdat;
    assign bus.timeout_irq = irq;
    assign bus.currmaster  = {{(32-IW){1'b0}}, grant};
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scenario and randomized checks of bus_rr_arbiter against a
// transaction-level round-robin model.
module tb_bus_rr_arbiter;
    localparam int N  = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   passes = 0;

    bus_rr_arbiter_if #(.MASTER_IFACE_CNT(N)) bus ();

    bus_rr_arbiter #(
        .MASTER_IFACE_CNT(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int pick_rr(int lastm, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(lastm + k) % N]) return (lastm + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_sval(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bus.s_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic idle_all();
        @(negedge clk);
        bus.valid   = '0;
        bus.s_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.s_valid !== 1'b0)
            $display("FAIL rst_sval got %b exp 0", bus.s_valid);
        else passes++;
        checks++;
        if (bus.ready !== 3'b000)
            $display("FAIL rst_ready got %b exp 000", bus.ready);
        else passes++;
        checks++;
        if (bus.timeout_irq !== 1'b0)
            $display("FAIL rst_irq got %b exp 0", bus.timeout_irq);
        else passes++;
        checks++;
        if (bus.currmaster !== 32'd0)
            $display("FAIL rst_cm got %0d exp 0", bus.currmaster);
        else passes++;
        @(negedge clk);
        resetn    = 1'b1;
        bus.valid = 3'b110;
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_valid !== 1'b0)
            $display("FAIL rst_early_arb got %b exp 0", bus.s_valid);
        else passes++;
        wait_sval(ok);
        checks++;
        if (!ok) $display("FAIL rst_first_grant got timeout exp s_valid");
        else passes++;
        checks++;
        if (bus.currmaster !== 32'd1)
            $display("FAIL rst_first_cm got %0d exp 1", bus.currmaster);
        else passes++;
        bus.s_ready = 1'b1;
        idle_all();
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        @(negedge clk);
        bus.addr[32 +: 32] = 32'h4000_0100;
        bus.wen[4 +: 4]    = 4'h0;
        bus.valid          = 3'b010;
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h4000_0100)
            $display("FAIL rd_req got v=%b a=%h exp v=1 a=40000100",
                     bus.s_valid, bus.s_addr);
        else passes++;
        checks++;
        if (bus.s_wen !== 4'h0 || bus.currmaster !== 32'd1)
            $display("FAIL rd_sel got wen=%h cm=%0d exp wen=0 cm=1",
                     bus.s_wen, bus.currmaster);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.ready !== 3'b000)
                $display("FAIL rd_wait got %b exp 000", bus.ready);
            else passes++;
        end
        @(negedge clk);
        rd            = $urandom();
        bus.s_rdata   = rd;
        bus.s_ready   = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 3'b010)
            $display("FAIL rd_ready got %b exp 010", bus.ready);
        else passes++;
        checks++;
        if (bus.rdata[32 +: 32] !== rd)
            $display("FAIL rd_data got %h exp %h", bus.rdata[32 +: 32], rd);
        else passes++;
        @(negedge clk);
        bus.s_ready = 1'b0;
        bus.valid   = '0;
        #1;
        checks++;
        if (bus.s_valid !== 1'b0 || bus.ready !== 3'b000)
            $display("FAIL rd_done got v=%b r=%b exp v=0 r=000",
                     bus.s_valid, bus.ready);
        else passes++;
        idle_all();
    endtask

    task automatic test_fairness();
        bit ok;
        int e;
        @(negedge clk);
        bus.valid = 3'b100;
        wait_sval(ok);
        bus.s_ready = 1'b1;
        @(negedge clk);
        bus.s_ready = 1'b0;
        bus.valid   = 3'b111;
        for (int k = 0; k < 6; k++) begin
            e = k % N;
            wait_sval(ok);
            checks++;
            if (!ok || bus.currmaster !== 32'(e))
                $display("FAIL rr_grant%0d got %0d exp %0d",
                         k, bus.currmaster, e);
            else passes++;
            @(negedge clk);
            bus.s_ready = 1'b1;
            #1;
            checks++;
            if (bus.ready !== 3'(1 << e))
                $display("FAIL rr_ready%0d got %b exp %b",
                         k, bus.ready, 3'(1 << e));
            else passes++;
            @(negedge clk);
            bus.s_ready = 1'b0;
            #1;
            checks++;
            if (bus.s_valid !== 1'b0 || bus.currmaster !== 32'(e))
                $display("FAIL rr_idle%0d got v=%b cm=%0d exp v=0 cm=%0d",
                         k, bus.s_valid, bus.currmaster, e);
            else passes++;
        end
        idle_all();
    endtask

    task automatic test_timeout();
        bit ok;
        @(negedge clk);
        bus.valid = 3'b100;
        wait_sval(ok);
        checks++;
        if (!ok || bus.currmaster !== 32'd2)
            $display("FAIL to_grant got %0d exp 2", bus.currmaster);
        else passes++;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.ready !== 3'b000 || bus.timeout_irq !== 1'b0)
                $display("FAIL to_wait%0d got r=%b irq=%b exp r=000 irq=0",
                         i, bus.ready, bus.timeout_irq);
            else passes++;
        end
        @(negedge clk);
        bus.s_rdata = 32'h0BAD_F00D;
        #1;
        checks++;
        if (bus.ready !== 3'b100 || bus.timeout_irq !== 1'b1)
            $display("FAIL to_fire got r=%b irq=%b exp r=100 irq=1",
                     bus.ready, bus.timeout_irq);
        else passes++;
        checks++;
        if (bus.rdata[64 +: 32] !== 32'hDEADBEEF)
            $display("FAIL to_rdata got %h exp deadbeef", bus.rdata[64 +: 32]);
        else passes++;
        checks++;
        if (bus.s_valid !== 1'b0 || bus.rdata[0 +: 32] !== 32'h0BAD_F00D)
            $display("FAIL to_sval got v=%b rd0=%h exp v=0 rd0=0badf00d",
                     bus.s_valid, bus.rdata[0 +: 32]);
        else passes++;
        @(negedge clk);
        bus.valid = '0;
        #1;
        checks++;
        if (bus.timeout_irq !== 1'b0 || bus.ready !== 3'b000)
            $display("FAIL to_pulse got irq=%b r=%b exp irq=0 r=000",
                     bus.timeout_irq, bus.ready);
        else passes++;
        idle_all();
    endtask

    task automatic test_timeout_vs_ready();
        bit ok;
        @(negedge clk);
        bus.valid = 3'b001;
        wait_sval(ok);
        repeat (TO - 1) @(negedge clk);
        @(negedge clk);
        bus.s_rdata = 32'h1234_5678;
        bus.s_ready = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 3'b001 || bus.timeout_irq !== 1'b0)
            $display("FAIL tr_ready got r=%b irq=%b exp r=001 irq=0",
                     bus.ready, bus.timeout_irq);
        else passes++;
        checks++;
        if (bus.rdata[0 +: 32] !== 32'h1234_5678 || bus.s_valid !== 1'b1)
            $display("FAIL tr_data got rd=%h v=%b exp rd=12345678 v=1",
                     bus.rdata[0 +: 32], bus.s_valid);
        else passes++;
        @(negedge clk);
        bus.s_ready = 1'b0;
        bus.valid   = '0;
        #1;
        checks++;
        if (bus.timeout_irq !== 1'b0)
            $display("FAIL tr_noirq got %b exp 0", bus.timeout_irq);
        else passes++;
        idle_all();
    endtask

    task automatic test_abort();
        bit ok;
        @(negedge clk);
        bus.valid = 3'b001;
        wait_sval(ok);
        checks++;
        if (!ok || bus.currmaster !== 32'd0)
            $display("FAIL ab_grant got %0d exp 0", bus.currmaster);
        else passes++;
        @(negedge clk);
        bus.valid = 3'b011;
        @(negedge clk);
        bus.valid = 3'b010;
        #1;
        checks++;
        if (bus.s_valid !== 1'b0 || bus.ready !== 3'b000)
            $display("FAIL ab_drop got v=%b r=%b exp v=0 r=000",
                     bus.s_valid, bus.ready);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_valid !== 1'b0 || bus.ready !== 3'b000)
            $display("FAIL ab_idle got v=%b r=%b exp v=0 r=000",
                     bus.s_valid, bus.ready);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_valid !== 1'b1 || bus.currmaster !== 32'd1)
            $display("FAIL ab_next got v=%b cm=%0d exp v=1 cm=1",
                     bus.s_valid, bus.currmaster);
        else passes++;
        bus.s_ready = 1'b1;
        idle_all();
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        @(negedge clk);
        bus.valid = 3'b100;
        wait_sval(ok);
        bus.s_ready = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 3'b100)
            $display("FAIL mr_pre got %b exp 100", bus.ready);
        else passes++;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 3'b000 || bus.s_valid !== 1'b0)
            $display("FAIL mr_async got r=%b v=%b exp r=000 v=0",
                     bus.ready, bus.s_valid);
        else passes++;
        checks++;
        if (bus.timeout_irq !== 1'b0 || bus.currmaster !== 32'd0)
            $display("FAIL mr_regs got irq=%b cm=%0d exp irq=0 cm=0",
                     bus.timeout_irq, bus.currmaster);
        else passes++;
        bus.s_ready = 1'b0;
        bus.valid   = 3'b111;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_valid !== 1'b0)
            $display("FAIL mr_early got %b exp 0", bus.s_valid);
        else passes++;
        wait_sval(ok);
        checks++;
        if (!ok || bus.currmaster !== 32'd0)
            $display("FAIL mr_first got %0d exp 0", bus.currmaster);
        else passes++;
        bus.s_ready = 1'b1;
        idle_all();
    endtask

    task automatic test_random();
        int          owner;
        int          lastm;
        int          grantm;
        int          waited;
        bit          tout;
        bit          sr;
        bit          esv;
        logic [N-1:0] v;
        logic [N-1:0] er;
        logic [31:0]  erd;
        resetn      = 1'b0;
        bus.valid   = '0;
        bus.s_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        owner  = -1;
        lastm  = N - 1;
        grantm = 0;
        waited = 0;
        v      = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(0, 7) == 0) v[m] = ~v[m];
                bus.addr[32*m +: 32] = $urandom();
            end
            sr          = ($urandom_range(0, 5) == 0);
            bus.valid   = v;
            bus.s_rdata = $urandom();
            bus.s_ready = sr;
            #1;
            tout = owner >= 0 && v[owner] && !sr && waited == TO;
            esv  = owner >= 0 && v[owner] && !tout;
            er   = '0;
            if (owner >= 0 && (sr || tout)) er[owner] = 1'b1;
            checks++;
            if (bus.ready !== er || bus.s_valid !== esv)
                $display("FAIL rnd_hs c=%0d got r=%b v=%b exp r=%b v=%b",
                         c, bus.ready, bus.s_valid, er, esv);
            else passes++;
            checks++;
            if (bus.timeout_irq !== tout || bus.currmaster !== 32'(grantm))
                $display("FAIL rnd_st c=%0d got irq=%b cm=%0d exp irq=%b cm=%0d",
                         c, bus.timeout_irq, bus.currmaster, tout, grantm);
            else passes++;
            if (owner >= 0) begin
                erd = tout ? 32'hDEADBEEF : bus.s_rdata;
                checks++;
                if (bus.rdata[32*owner +: 32] !== erd)
                    $display("FAIL rnd_rd c=%0d got %h exp %h",
                             c, bus.rdata[32*owner +: 32], erd);
                else passes++;
            end
            if (esv) begin
                checks++;
                if (bus.s_addr !== bus.addr[32*owner +: 32])
                    $display("FAIL rnd_addr c=%0d got %h exp %h",
                             c, bus.s_addr, bus.addr[32*owner +: 32]);
                else passes++;
            end
            if (owner < 0) begin
                if (|v) begin
                    owner  = pick_rr(lastm, v);
                    grantm = owner;
                    waited = 0;
                end
            end else if (sr || !v[owner] || tout) begin
                lastm = owner;
                owner = -1;
            end else begin
                waited++;
            end
        end
        idle_all();
    endtask

    initial begin
        resetn      = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.wen     = '0;
        bus.valid   = '0;
        bus.s_rdata = '0;
        bus.s_ready = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_timeout();
        test_timeout_vs_ready();
        test_abort();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter MASTER_IFACE_CNT, default 3: number of requesting masters, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum cycles a granted transaction waits for s_ready before forced completion, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports addr/wdata/rdata, input/input/output, 32*MASTER_IFACE_CNT each: per-master busses; master i occupies bits [32*i+:32].
REQ-006 SHALL have port wen, input, 4*MASTER_IFACE_CNT: per-master byte write strobes; all zero means read.
REQ-007 SHALL have ports valid/ready, input/output, MASTER_IFACE_CNT each: per-master request and completion.
REQ-008 SHALL have ports s_addr/s_wdata/s_wen/s_valid, outputs, 32/32/4/1: slave-side request.
REQ-009 SHALL have ports s_rdata/s_ready, inputs, 32/1: slave-side response.
REQ-010 SHALL have port currmaster, output, 32: index of the granted master, zero-extended.
REQ-011 SHALL have port timeout_irq, output, 1: one-cycle pulse on forced completion.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 IDLE: when any valid bit is set, the arbiter SHALL register grant as the first requesting index found scanning upward from (last+1) modulo MASTER_IFACE_CNT, then enter BUSY the next cycle; arbitration latency SHALL be exactly 1 cycle.
REQ-014 IDLE: s_valid SHALL be 0 and all ready bits SHALL be 0.
REQ-015 BUSY: s_addr, s_wdata, s_wen and s_valid SHALL combinationally mirror the granted master's addr, wdata, wen and valid.
REQ-016 BUSY: ready[grant] SHALL equal s_ready combinationally; all other ready bits SHALL be 0.
REQ-017 rdata for every master SHALL be driven with s_rdata; only the granted master's ready bit qualifies it.
REQ-018 BUSY with s_ready=1: the FSM SHALL return to IDLE, and last SHALL be set to grant.
REQ-019 BUSY with valid[grant]=0 (master abort) before s_ready: the FSM SHALL return to IDLE, last SHALL be set to grant, and no ready SHALL be issued.
REQ-020 BUSY: a 16-bit wait counter SHALL increment each cycle that s_ready=0, and SHALL clear on entry to BUSY.
REQ-021 When the wait counter equals TIMEOUT_CYCLES and s_ready=0, the arbiter SHALL drive ready[grant]=1, override rdata[grant] to 32'hDEADBEEF for that cycle, force s_valid=0, pulse timeout_irq for 1 cycle, and return to IDLE.
REQ-022 When s_ready and the timeout condition coincide, s_ready SHALL win: normal completion, no irq.
REQ-023 Requests arriving while BUSY SHALL be held pending; the arbiter SHALL NOT drop them, and SHALL evaluate them in the next IDLE cycle.
REQ-024 Fairness: with all masters continuously requesting, each master SHALL receive exactly one grant per MASTER_IFACE_CNT consecutive grants.
REQ-025 currmaster SHALL hold the grant register value in both states; it SHALL be updated only at arbitration.

Reset
REQ-026 While resetn=0: state SHALL be IDLE, grant SHALL be 0, last SHALL be MASTER_IFACE_CNT-1 (master 0 wins first), the wait counter SHALL be 0, s_valid SHALL be 0, all ready bits SHALL be 0, timeout_irq SHALL be 0, and currmaster SHALL be 0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the transaction immediately, with no ready or irq to any master.
REQ-028 Reset deassertion SHALL be synchronised internally; the first arbitration SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-029 The bench SHALL cover: single read, master 1 valid, addr=0x40000100, s_ready 3 cycles after s_valid -> ready[1] pulses in the same cycle as s_ready, and rdata[1]=s_rdata.
REQ-030 The bench SHALL cover: all 3 masters continuously valid, slave ready after 1 cycle -> grant order 0,1,2,0,1,2, and currmaster tracks that order.
REQ-031 The bench SHALL cover: master 2 granted, slave never ready, TIMEOUT_CYCLES=8 -> after 8 waiting cycles ready[2]=1, rdata[2]=0xDEADBEEF, one timeout_irq pulse, and s_valid=0 in that cycle.
REQ-032 The bench SHALL cover: s_ready asserted in the same cycle as timeout -> normal completion, timeout_irq stays 0.
REQ-033 The bench SHALL cover: master 0 drops valid mid-BUSY -> IDLE the next cycle, no ready, and the pending master 1 is granted next.
REQ-034 The bench SHALL cover: resetn pulsed low during BUSY -> all outputs reach their reset values asynchronously, and after release master 0 wins first.
